// File: rtl/uart_mem_bridge.sv
// Host-side command engine: parses fixed-length 'W'/'R' frames from the UART receiver,
// issues one memory access per frame and returns a single response byte.
module uart_mem_bridge #(
    parameter int unsigned ADDR_W         = 16,
    parameter int unsigned TIMEOUT_CYCLES = 32000,
    parameter int unsigned TO_BITS        = 15,
    parameter logic [7:0]  CMD_WR         = 8'h57,
    parameter logic [7:0]  CMD_RD         = 8'h52,
    parameter logic [7:0]  RSP_ACK        = 8'h06,
    parameter logic [7:0]  RSP_NAK        = 8'h15
) (
    input  logic              iClock,
    input  logic              iReset_n,
    input  logic [7:0]        iRxByte,
    input  logic              iRxReady,
    input  logic              iRxError,
    output logic [7:0]        oTxByte,
    output logic              oTxReady,
    input  logic              iTxSent,
    output logic              oMemReq,
    output logic              oMemWe,
    output logic [ADDR_W-1:0] oMemAddr,
    output logic [7:0]        oMemWrData,
    input  logic              iMemAck,
    input  logic [7:0]        iMemRdData,
    output logic              oFrameAbort,
    output logic              oOverrun
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR_HI,
        S_ADDR_LO,
        S_DATA,
        S_MEM,
        S_TX_START,
        S_TX_WAIT
    } state_t;

    state_t              state_q;
    logic [TO_BITS-1:0]  to_cnt_q;
    logic [7:0]          addr_hi_q;
    logic [7:0]          tx_byte_q;
    logic                tx_ready_q;
    logic                mem_req_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [7:0]          mem_wr_data_q;
    logic                frame_abort_q;
    logic                overrun_q;
    logic                timeout_hit;
    logic                busy;

    always_comb begin
        timeout_hit = (to_cnt_q == TO_BITS'(TIMEOUT_CYCLES - 1));
        busy        = (state_q == S_MEM) || (state_q == S_TX_START) || (state_q == S_TX_WAIT);
    end

    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            state_q       <= S_IDLE;
            to_cnt_q      <= '0;
            addr_hi_q     <= '0;
            tx_byte_q     <= '0;
            tx_ready_q    <= 1'b0;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wr_data_q <= '0;
            frame_abort_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            tx_ready_q    <= 1'b0;
            frame_abort_q <= 1'b0;
            overrun_q     <= iRxReady && busy;

            case (state_q)
                S_IDLE: begin
                    to_cnt_q <= '0;
                    if (iRxReady) begin
                        if (iRxByte == CMD_WR || iRxByte == CMD_RD) begin
                            mem_we_q <= (iRxByte == CMD_WR);
                            state_q  <= S_ADDR_HI;
                        end else begin
                            tx_byte_q <= RSP_NAK;
                            state_q   <= S_TX_START;
                        end
                    end
                end

                S_ADDR_HI, S_ADDR_LO, S_DATA: begin
                    // A receive error outranks a byte arriving in the same cycle.
                    if (iRxError || timeout_hit) begin
                        frame_abort_q <= 1'b1;
                        to_cnt_q      <= '0;
                        state_q       <= S_IDLE;
                    end else if (iRxReady) begin
                        to_cnt_q <= '0;
                        if (state_q == S_ADDR_HI) begin
                            addr_hi_q <= iRxByte;
                            state_q   <= S_ADDR_LO;
                        end else if (state_q == S_ADDR_LO) begin
                            mem_addr_q <= ADDR_W'({addr_hi_q, iRxByte});
                            if (mem_we_q) begin
                                state_q <= S_DATA;
                            end else begin
                                mem_req_q <= 1'b1;
                                state_q   <= S_MEM;
                            end
                        end else begin
                            mem_wr_data_q <= iRxByte;
                            mem_req_q     <= 1'b1;
                            state_q       <= S_MEM;
                        end
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
                end

                S_MEM: begin
                    to_cnt_q <= '0;
                    if (iMemAck && mem_req_q) begin
                        mem_req_q  <= 1'b0;
                        tx_byte_q  <= mem_we_q ? RSP_ACK : iMemRdData;
                        tx_ready_q <= 1'b1;
                        state_q    <= S_TX_START;
                    end
                end

                // Arriving from MEM the strobe is already raised; arriving from IDLE (NAK)
                // it is raised here, so the NAK strobe lands one cycle later.
                S_TX_START: begin
                    to_cnt_q <= '0;
                    if (tx_ready_q) begin
                        state_q <= S_TX_WAIT;
                    end else begin
                        tx_ready_q <= 1'b1;
                    end
                end

                S_TX_WAIT: begin
                    to_cnt_q <= '0;
                    if (iTxSent) begin
                        state_q <= S_IDLE;
                    end
                end

                default: begin
                    to_cnt_q <= '0;
                    state_q  <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        oTxByte     = tx_byte_q;
        oTxReady    = tx_ready_q;
        oMemReq     = mem_req_q;
        oMemWe      = mem_we_q;
        oMemAddr    = mem_addr_q;
        oMemWrData  = mem_wr_data_q;
        oFrameAbort = frame_abort_q;
        oOverrun    = overrun_q;
    end

endmodule

// File: doc/uart_mem_bridge.md
# uart_mem_bridge

Byte-level command engine sitting on the host side of `uart_ctrl` in `mem_mgr`. Consumes received bytes, parses fixed-length read and write frames, and issues single-byte accesses on a request/acknowledge memory port. Returns exactly one response byte per completed frame through the UART transmit handshake. It also discards malformed or stalled frames.

## Interface

- `ADDR_W`, 16: memory address width, 1..16. Frame address bits above `ADDR_W` are dropped.
- `TIMEOUT_CYCLES`, 32000: inter-byte timeout in clocks, equal to 1 ms at 32 MHz.
- `TO_BITS`, 15: width of the timeout counter. Must satisfy 2^TO_BITS > TIMEOUT_CYCLES.
- `CMD_WR`, 8'h57: write command byte ('W').
- `CMD_RD`, 8'h52: read command byte ('R').
- `RSP_ACK`, 8'h06: write acknowledge byte.
- `RSP_NAK`, 8'h15: unknown-command response byte.

Ports. One clock; reset is asynchronous and active-low.

- `iClock` in 1: system clock, the same clock as `uart_ctrl`.
- `iReset_n` in 1: asynchronous, active-low reset.
- `iRxByte` in 8: received byte. Valid while `iRxReady` is high.
- `iRxReady` in 1: one-cycle strobe, received byte valid.
- `iRxError` in 1: one-cycle strobe, framing error on the receiver.
- `oTxByte` out 8: response byte. Held stable from the `oTxReady` cycle until `iTxSent`.
- `oTxReady` out 1: one-cycle transmit request strobe.
- `iTxSent` in 1: one-cycle strobe, stop bit finished.
- `oMemReq` out 1: memory request. Held until acknowledged.
- `oMemWe` out 1: 1 = write, 0 = read. Valid with `oMemReq`.
- `oMemAddr` out ADDR_W: access address.
- `oMemWrData` out 8: write data.
- `iMemAck` in 1: one-cycle acknowledge. Read data is valid in the same cycle.
- `iMemRdData` in 8: read data.
- `oFrameAbort` out 1: one-cycle pulse, partial frame discarded.
- `oOverrun` out 1: one-cycle pulse, received byte dropped while busy.

## Operation

- Frame formats, in byte order:
  - Write: `CMD_WR`, addr[15:8], addr[7:0], data. Response is `RSP_ACK`.
  - Read: `CMD_RD`, addr[15:8], addr[7:0]. Response is the data byte read.
  - Any other first byte: response is `RSP_NAK`. No memory access is made.
- States: IDLE, ADDR_HI, ADDR_LO, DATA, MEM, TX_START, TX_WAIT.
- IDLE, on `iRxReady`:
  - `CMD_WR` or `CMD_RD`: latch the command type, go to ADDR_HI.
  - Any other byte: load `RSP_NAK`, go to TX_START.
- ADDR_HI, on `iRxReady`: latch the high address byte, go to ADDR_LO.
- ADDR_LO, on `iRxReady`: latch the low address byte. Write goes to DATA; read goes to MEM.
- DATA, on `iRxReady`: latch the write data, go to MEM.
- MEM: `oMemReq` is 1 and `oMemWe` equals the command type.
  - On `iMemAck`: `oMemReq` is 0 the next cycle.
  - Read: load `iMemRdData` into `oTxByte`. Write: load `RSP_ACK`.
  - Then go to TX_START.
- TX_START: `oTxReady` = 1 for exactly one cycle, then go to TX_WAIT.
- TX_WAIT: on `iTxSent`, go to IDLE.
- Abort rules, applying in ADDR_HI, ADDR_LO and DATA only:
  - `iRxError`, or the timeout counter reaching TIMEOUT_CYCLES-1, sends the block to IDLE with a one-cycle `oFrameAbort`. No response byte is sent.
  - The timeout counter clears on entry to each of these states and on every accepted byte.
- `iRxError` in IDLE, MEM, TX_START or TX_WAIT is ignored.
- `iRxReady` in MEM, TX_START or TX_WAIT: the byte is dropped, `oOverrun` pulses, and the state is unchanged.
- `iRxReady` and `iRxError` asserted in the same cycle: the error wins.
- The effective address is {addr_hi, addr_lo}[ADDR_W-1:0].

## Timing

- Reset values: state IDLE, with every output at 0:
  - `oTxByte`, `oTxReady`, `oMemReq`, `oMemWe`, `oMemAddr`, `oMemWrData`, `oFrameAbort`, `oOverrun`.
  - The timeout counter is also 0.
- All outputs are registered.
- Reset mid-frame or mid-access drops `oMemReq` and `oTxReady` asynchronously. No resume.
- Last frame byte strobed in cycle N: `oMemReq` is 1 from cycle N+1.
- `iMemAck` in cycle M:
  - `oMemReq` is 0 and the state is TX_START at M+1.
  - `oTxReady` is high for cycle M+1 only.
- NAK path: command byte in cycle N gives `oTxReady` at cycle N+2.
- `oMemAddr`, `oMemWe` and `oMemWrData` are stable for the whole `oMemReq` window.
- `oTxByte` is stable from TX_START until the `iTxSent` cycle.
- `iMemAck` with `oMemReq` low is ignored.
- The first byte of the next frame is accepted the cycle after `iTxSent`.
- Abort: the timeout fires TIMEOUT_CYCLES clocks after entry or after the last accepted byte. `oFrameAbort` goes high the next cycle, with the state at IDLE.

## Test plan

- Write: bytes 57 12 34 A5 → one `oMemReq` with `oMemWe`=1, `oMemAddr`=1234, `oMemWrData`=A5. A 3-cycle ack delay is respected. Then `oTxReady` pulse with `oTxByte`=06.
- Read: bytes 52 00 10, memory returns 3C on ack → `oMemWe`=0, `oMemAddr`=0010. `oTxByte`=3C, `oTxReady` at ack+1. `oTxByte` held until `iTxSent`.
- Unknown: byte 41 → no `oMemReq`. `oTxByte`=15, `oTxReady` two cycles after the byte strobe.
- Timeout: bytes 57 12, then silence (TIMEOUT_CYCLES=20) → `oFrameAbort` at cycle 21 after the 12 strobe. No transmit. Next frame 52 00 01 completes normally.
- Error: `iRxError` after 57 AB → abort pulse, state IDLE. Same-cycle `iRxReady` plus `iRxError` also aborts.
- Overrun and reset: a byte strobed during TX_WAIT → `oOverrun` pulse, response unchanged. `iReset_n` low during MEM → `oMemReq` low immediately, and the following frame works.
